// File: rtl/rank_sort_pkg.sv
// Shared constants and helpers for the rank-based sorting pipeline.
package rank_sort_pkg;

  localparam int N_DEF   = 8;
  localparam int W_DEF   = 16;
  localparam int VEC_MAX = 512;  // widest flat vector: 16 elements x 32 bits

  // Bits needed to hold a rank in 0..n-1.
  function automatic int rank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Element i of a flat vector of w-bit elements; the caller truncates to w.
  function automatic logic [31:0] elem_sel(input logic [VEC_MAX-1:0] v, input int i, input int w);
    return 32'(v >> (i * w));
  endfunction

endpackage

// File: rtl/rank_sort_rank.sv
// Rank of element IDX: compare bits against every element and popcount of predecessors.
module rank_sort_rank
  import rank_sort_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int W   = W_DEF,
  parameter int IDX = 0
) (
  input  logic [N-1:0][W-1:0]   vec_i,
  output logic [N-1:0]          lt_o,
  output logic [N-1:0]          eq_o,
  input  logic [N-1:0]          lt_i,
  input  logic [N-1:0]          eq_i,
  input  logic                  desc_i,
  output logic [rank_w(N)-1:0]  rank_o
);

  localparam int RW = rank_w(N);

  logic [N-1:0] prec;

  // lt_o[j]: element j is smaller than element IDX
  always_comb begin
    lt_o = '0;
    eq_o = '0;
    for (int j = 0; j < N; j++) begin
      lt_o[j] = vec_i[j] < vec_i[IDX];
      eq_o[j] = vec_i[j] == vec_i[IDX];
    end
  end

  // Equal elements with a lower index always precede, which keeps ranks a permutation.
  always_comb begin
    prec   = '0;
    rank_o = '0;
    for (int j = 0; j < N; j++) begin
      prec[j] = (desc_i ? !(lt_i[j] || eq_i[j]) : lt_i[j]) || (eq_i[j] && (j < IDX));
      rank_o  = rank_o + RW'(prec[j]);
    end
  end

endmodule

// File: rtl/rank_sort_pipe.sv
// 3-stage rank sorter: compare matrix -> rank popcount -> scatter, 1 vector/cycle.
// Define RANK_SORT_IDX_EN to add out_idx (source index of each sorted slot).
module rank_sort_pipe
  import rank_sort_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*W-1:0]          in_data,
  input  logic                    in_desc,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef RANK_SORT_IDX_EN
  output logic [N*rank_w(N)-1:0]  out_idx,
`endif
  output logic [N*W-1:0]          out_data
);

  localparam int RW     = rank_w(N);
  localparam int STAGES = 3;

  logic                     adv;
  logic [STAGES-1:0]        vld_pipe;
  logic [N-1:0][W-1:0]      in_vec, s1_data_q, s2_data_q, out_data_q, scat_d;
  logic [N-1:0][N-1:0]      lt_d, eq_d, s1_lt_q, s1_eq_q;
  logic [N-1:0][RW-1:0]     rank_d, s2_rank_q;
  logic                     s1_desc_q;

  assign out_valid = vld_pipe[STAGES-1];
  assign in_ready  = !(out_valid && !out_ready);
  assign adv       = in_ready;  // whole pipe moves or freezes as one
  assign out_data  = out_data_q;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign in_vec[i] = W'(elem_sel(VEC_MAX'(in_data), i, W));
  end

  for (genvar i = 0; i < N; i++) begin : g_rank
    rank_sort_rank #(.N(N), .W(W), .IDX(i)) u_rank (
      .vec_i  (in_vec),
      .lt_o   (lt_d[i]),
      .eq_o   (eq_d[i]),
      .lt_i   (s1_lt_q[i]),
      .eq_i   (s1_eq_q[i]),
      .desc_i (s1_desc_q),
      .rank_o (rank_d[i])
    );
  end

  always_comb begin
    scat_d = '0;
    for (int i = 0; i < N; i++) scat_d[s2_rank_q[i]] = s2_data_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      s1_data_q  <= '0;
      s1_lt_q    <= '0;
      s1_eq_q    <= '0;
      s1_desc_q  <= 1'b0;
      s2_data_q  <= '0;
      s2_rank_q  <= '0;
      out_data_q <= '0;
    end else if (adv) begin
      vld_pipe   <= {vld_pipe[STAGES-2:0], in_valid};
      s1_data_q  <= in_vec;
      s1_lt_q    <= lt_d;
      s1_eq_q    <= eq_d;
      s1_desc_q  <= in_desc;
      s2_data_q  <= s1_data_q;
      s2_rank_q  <= rank_d;
      out_data_q <= scat_d;
    end
  end

`ifdef RANK_SORT_IDX_EN
  logic [N-1:0][RW-1:0] idx_d, out_idx_q;

  assign out_idx = out_idx_q;

  always_comb begin
    idx_d = '0;
    for (int i = 0; i < N; i++) idx_d[s2_rank_q[i]] = RW'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_idx_q <= '0;
    else if (adv) out_idx_q <= idx_d;
  end
`endif

endmodule

// File: doc/rank_sort_pipe.md
RANK_SORT_PIPE -- requirements
Module: rank_sort_pipe

Interface
REQ-001 SHALL have parameter N, default 8, number of elements sorted per vector (2..16).
REQ-002 SHALL have parameter W, default 16, element width in bits (1..32).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, input vector valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a vector.
REQ-007 SHALL have port in_data, input, N*W, element i at bits [i*W +: W], unsigned.
REQ-008 SHALL have port in_desc, input, 1, per-vector order: 0 ascending, 1 descending.
REQ-009 SHALL have port out_valid, output, 1, sorted vector valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the sorted vector.
REQ-011 SHALL have port out_data, output, N*W, sorted element k at bits [k*W +: W].

Function
REQ-012 SHALL accept a vector on any rising edge where in_valid && in_ready are both high.
REQ-013 SHALL form a 3-stage pipeline: S1 registers the pairwise compare matrix with data and in_desc; S2 registers the per-element rank (popcount, $clog2(N) bits); S3 scatters each element to out_data[rank].
REQ-014 SHALL assert out_valid exactly 3 cycles after acceptance when there is no backpressure, and SHALL sustain 1 vector per cycle.
REQ-015 SHALL, in ascending mode, compute rank(i) as the count of j where in[j] < in[i], or where in[j] == in[i] and j < i.
REQ-016 SHALL, in descending mode, compute rank(i) as the count of j where in[j] > in[i], or where in[j] == in[i] and j < i.
REQ-017 SHALL resolve ties stably (lower input index goes to the lower output position), so the ranks always form a permutation of 0..N-1.
REQ-018 SHALL drive in_ready = !(out_valid && !out_ready), and SHALL stall all stages together while the S3 holding register is full and not accepted.
REQ-019 SHALL keep out_data and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL allow acceptance and output handoff on the same edge with no bubble.
REQ-021 SHALL track per-stage valid bits so that bubbles propagate and no data is duplicated or dropped.
REQ-022 SHALL sample in_desc per vector, so mixed-order vectors may be interleaved back-to-back.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear all stage valid bits, out_valid, and out_data, and SHALL hold in_ready at 1 during reset.
REQ-024 SHALL discard in-flight vectors on reset mid-operation, with the first out_valid after release arising only from a newly accepted vector.

Configuration
REQ-025 SHALL, with RANK_SORT_IDX_EN defined, add output out_idx (N*$clog2(N) bits) giving the original input index of each sorted position, timed and held with out_data.
REQ-026 SHALL, without RANK_SORT_IDX_EN, omit the out_idx port and its registers.

Structure
REQ-027 SHALL place the rank-width function, the element-select helper, and the default N/W constants in the shared package rank_sort_pkg.
REQ-028 SHALL implement the per-element rank computation as sub-module rank_sort_rank (one element versus all others, parameterised by N, W, and index), instantiated N times.

Verification
REQ-029 SHALL verify: N=8, W=16, ascending input {5,3,9,1,7,2,8,4} -> out {1,2,3,4,5,7,8,9}, with out_valid 3 cycles after acceptance.
REQ-030 SHALL verify: the same input with in_desc=1 -> out {9,8,7,5,4,3,2,1}; under RANK_SORT_IDX_EN, out_idx = {2,6,4,0,7,1,5,3}.
REQ-031 SHALL verify: all-equal input {0x00AA x8} -> out unchanged, and out_idx {0..7} in order (stability).
REQ-032 SHALL verify: 4 back-to-back vectors with out_ready held low for 5 cycles -> in_ready drops, the first output is held stable, and all 4 outputs emerge in order with none lost.
REQ-033 SHALL verify: extremes {0xFFFF,0,0xFFFF,0,1,0xFFFE,0,1} ascending -> {0,0,0,1,1,0xFFFE,0xFFFF,0xFFFF}.
REQ-034 SHALL verify: rst_n asserted while 2 vectors are in flight -> out_valid is 0 immediately, and no stale output appears after release.
